// File: rtl/ime_pkg.sv
// Shared types and helpers for the frame-level metric accumulator.
package ime_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_EMIT  = 2'd2
  } ime_state_e;

  localparam int IME_W_IN_DEF  = 32;
  localparam int IME_W_SUM_DEF = 48;
  localparam int IME_K_MAX_DEF = 4096;
  localparam int IME_SAT_W     = 64;

  typedef struct packed {
    logic signed [IME_SAT_W-1:0] sum;
    logic                        ovf;
  } sat_res_t;

  // Operands are sign-extended to IME_SAT_W; result clamps to a w-bit signed range.
  function automatic sat_res_t sat_add_signed(input logic signed [IME_SAT_W-1:0] a,
                                              input logic signed [IME_SAT_W-1:0] b,
                                              input int unsigned w);
    sat_res_t res;
    logic signed [IME_SAT_W:0] s;
    logic signed [IME_SAT_W:0] hi;
    logic signed [IME_SAT_W:0] lo;
    s  = (IME_SAT_W+1)'(a) + (IME_SAT_W+1)'(b);
    hi = ((IME_SAT_W+1)'(1) <<< (w - 1)) - (IME_SAT_W+1)'(1);
    lo = -((IME_SAT_W+1)'(1) <<< (w - 1));
    res.sum = s[IME_SAT_W-1:0];
    res.ovf = 1'b0;
    if (s > hi) begin
      res.sum = hi[IME_SAT_W-1:0];
      res.ovf = 1'b1;
    end else if (s < lo) begin
      res.sum = lo[IME_SAT_W-1:0];
      res.ovf = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/ime_accumulator.sv
// Sums signed per-element partials over a frame and emits one fail-closed result.
// state    | meaning
// ST_IDLE  | no open frame, next accepted beat opens one
// ST_ACCUM | frame open, summing beats
// ST_EMIT  | result held on out_*, input stalled until handshake
module ime_accumulator
  import ime_pkg::*;
#(
  parameter  int W_IN  = IME_W_IN_DEF,
  parameter  int W_SUM = IME_W_SUM_DEF,
  parameter  int K_MAX = IME_K_MAX_DEF,
  localparam int W_CNT = $clog2(K_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [W_IN-1:0]  in_partial_acc,
  input  logic [7:0]              in_tuser,
  input  logic                    in_last,
  input  logic                    in_poison,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [W_SUM-1:0] out_sum,
  output logic [W_CNT-1:0]        out_count,
  output logic [7:0]              out_tuser,
  output logic                    out_poison,
  output logic                    out_saturated,
  output logic                    frame_active
);

  localparam int unsigned SUM_W = W_SUM;

  ime_state_e state_q, state_d;

  logic signed [W_SUM-1:0] acc_q, acc_d, acc_base, acc_cand;
  logic [W_CNT-1:0]        cnt_q, cnt_d;
  logic [7:0]              tuser_q;
  logic                    poison_q, poison_d;
  logic                    sat_q, sat_d;
  logic                    accept, first, beat_poison, forced, close, fits;
  sat_res_t                add_r;

  always_comb begin
    state_d     = state_q;
    in_ready    = (state_q != ST_EMIT);
    accept      = in_valid && in_ready;
    first       = (state_q == ST_IDLE);
    acc_base    = first ? '0 : acc_q;
    beat_poison = in_poison | (!first && (in_tuser != tuser_q));
    add_r       = sat_add_signed(IME_SAT_W'(acc_base), IME_SAT_W'(in_partial_acc), SUM_W);
    acc_cand    = add_r.sum[W_SUM-1:0];
    fits        = (IME_SAT_W'(acc_cand) == add_r.sum);

    // Poisoned beats count but never touch the running sum.
    if (beat_poison) begin
      acc_d = acc_base;
      sat_d = !first && sat_q;
    end else begin
      acc_d = acc_cand;
      sat_d = (!first && sat_q) | add_r.ovf | !fits;
    end

    cnt_d    = (first ? '0 : cnt_q) + W_CNT'(1);
    forced   = !in_last && (cnt_d == W_CNT'(K_MAX));
    close    = in_last || forced;
    poison_d = (!first && poison_q) | beat_poison | forced;

    unique case (state_q)
      ST_IDLE, ST_ACCUM: if (accept) state_d = close ? ST_EMIT : ST_ACCUM;
      ST_EMIT:           if (out_ready) state_d = ST_IDLE;
      default:           state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      acc_q         <= '0;
      cnt_q         <= '0;
      tuser_q       <= '0;
      poison_q      <= 1'b0;
      sat_q         <= 1'b0;
      out_sum       <= '0;
      out_count     <= '0;
      out_tuser     <= '0;
      out_poison    <= 1'b0;
      out_saturated <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        acc_q    <= acc_d;
        cnt_q    <= cnt_d;
        poison_q <= poison_d;
        sat_q    <= sat_d;
        if (first) tuser_q <= in_tuser;
        if (close) begin
          out_sum       <= poison_d ? '0 : acc_d;
          out_count     <= cnt_d;
          out_tuser     <= first ? in_tuser : tuser_q;
          out_poison    <= poison_d;
          out_saturated <= sat_d;
        end
      end
    end
  end

  assign out_valid    = (state_q == ST_EMIT);
  assign frame_active = (state_q == ST_ACCUM);

endmodule

// File: tb/tb_ime_accumulator.sv
// Directed bench for ime_accumulator: default, narrow-sum and small-frame instances.
module tb_ime_accumulator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]         in_valid_v;
  logic signed [31:0] in_partial;
  logic [7:0]         in_tuser;
  logic               in_last, in_poison, out_ready;

  logic [2:0]         in_ready_v, out_valid_v, out_poison_v, out_sat_v, frame_active_v;
  logic signed [47:0] sum0, sum2;
  logic signed [33:0] sum1;
  logic [12:0]        cnt0, cnt1;
  logic [2:0]         cnt2;
  logic [7:0]         tu0, tu1, tu2;

  int    n_vec  = 0;
  int    n_miss = 0;
  string cur    = "init";

  ime_accumulator u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_partial_acc(in_partial), .in_tuser(in_tuser), .in_last(in_last), .in_poison(in_poison),
    .out_valid(out_valid_v[0]), .out_ready(out_ready), .out_sum(sum0), .out_count(cnt0),
    .out_tuser(tu0), .out_poison(out_poison_v[0]), .out_saturated(out_sat_v[0]),
    .frame_active(frame_active_v[0]));

  ime_accumulator #(.W_SUM(34)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_partial_acc(in_partial), .in_tuser(in_tuser), .in_last(in_last), .in_poison(in_poison),
    .out_valid(out_valid_v[1]), .out_ready(out_ready), .out_sum(sum1), .out_count(cnt1),
    .out_tuser(tu1), .out_poison(out_poison_v[1]), .out_saturated(out_sat_v[1]),
    .frame_active(frame_active_v[1]));

  ime_accumulator #(.K_MAX(4)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .in_partial_acc(in_partial), .in_tuser(in_tuser), .in_last(in_last), .in_poison(in_poison),
    .out_valid(out_valid_v[2]), .out_ready(out_ready), .out_sum(sum2), .out_count(cnt2),
    .out_tuser(tu2), .out_poison(out_poison_v[2]), .out_saturated(out_sat_v[2]),
    .frame_active(frame_active_v[2]));

  function automatic logic [63:0] g_sum(input int s);
    case (s)
      0:       return 64'(sum0);
      1:       return 64'(sum1);
      default: return 64'(sum2);
    endcase
  endfunction

  function automatic logic [63:0] g_cnt(input int s);
    case (s)
      0:       return 64'(cnt0);
      1:       return 64'(cnt1);
      default: return 64'(cnt2);
    endcase
  endfunction

  function automatic logic [63:0] g_tu(input int s);
    case (s)
      0:       return 64'(tu0);
      1:       return 64'(tu1);
      default: return 64'(tu2);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s/%s: got 0x%0h, expected 0x%0h", cur, tag, obs, exp);
    end
  endtask

  task automatic beat(input int s, input logic signed [31:0] p, input logic [7:0] tg,
                      input logic l, input logic pz);
    int n;
    n = 0;
    @(negedge clk);
    in_partial    = p;
    in_tuser      = tg;
    in_last       = l;
    in_poison     = pz;
    in_valid_v[s] = 1'b1;
    while (!in_ready_v[s] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 64'(in_ready_v[s]), 64'd1);
    @(posedge clk);
    #1;
    in_valid_v[s] = 1'b0;
  endtask

  // Sampled at the first negedge after the closing beat's edge.
  task automatic expect_frame(input int s, input logic [63:0] sum, input logic [63:0] cnt,
                              input logic [7:0] tg, input logic pz, input logic sat);
    @(negedge clk);
    chk("out_valid", 64'(out_valid_v[s]), 64'd1);
    chk("out_sum", g_sum(s), sum);
    chk("out_count", g_cnt(s), cnt);
    chk("out_tuser", g_tu(s), 64'(tg));
    chk("out_poison", 64'(out_poison_v[s]), 64'(pz));
    chk("out_saturated", 64'(out_sat_v[s]), 64'(sat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    in_valid_v = '0;
    in_partial = '0;
    in_tuser   = '0;
    in_last    = 1'b0;
    in_poison  = 1'b0;
    out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    cur = "reset";
    for (int s = 0; s < 3; s++) begin
      chk("out_valid", 64'(out_valid_v[s]), 64'd0);
      chk("in_ready", 64'(in_ready_v[s]), 64'd1);
      chk("frame_active", 64'(frame_active_v[s]), 64'd0);
      chk("out_sum", g_sum(s), 64'd0);
    end

    cur = "basic";
    beat(0, 10, 8'h21, 1'b0, 1'b0);
    chk("frame_active", 64'(frame_active_v[0]), 64'd1);
    beat(0, -3, 8'h21, 1'b0, 1'b0);
    beat(0, 5, 8'h21, 1'b1, 1'b0);
    expect_frame(0, 64'd12, 64'd3, 8'h21, 1'b0, 1'b0);
    chk("frame_active_emit", 64'(frame_active_v[0]), 64'd0);

    cur = "sat_pos";
    repeat (5) beat(1, 32'sh7FFF_FFFF, 8'h02, 1'b0, 1'b0);
    beat(1, -1, 8'h02, 1'b1, 1'b0);
    expect_frame(1, 64'h1_FFFF_FFFE, 64'd6, 8'h02, 1'b0, 1'b1);

    cur = "sat_neg";
    repeat (4) beat(1, 32'sh8000_0000, 8'h03, 1'b0, 1'b0);
    beat(1, 32'sh8000_0000, 8'h03, 1'b1, 1'b0);
    expect_frame(1, 64'hFFFF_FFFE_0000_0000, 64'd5, 8'h03, 1'b0, 1'b1);

    cur = "poison_beat";
    beat(0, 7, 8'h05, 1'b0, 1'b0);
    beat(0, 9, 8'h05, 1'b0, 1'b1);
    beat(0, 4, 8'h05, 1'b1, 1'b0);
    expect_frame(0, 64'd0, 64'd3, 8'h05, 1'b1, 1'b0);

    cur = "tag_mismatch";
    beat(0, 1, 8'h03, 1'b0, 1'b0);
    beat(0, 2, 8'h04, 1'b1, 1'b0);
    expect_frame(0, 64'd0, 64'd2, 8'h03, 1'b1, 1'b0);

    cur = "kmax_force";
    repeat (4) beat(2, 1, 8'h40, 1'b0, 1'b0);
    expect_frame(2, 64'd0, 64'd4, 8'h40, 1'b1, 1'b0);
    cur = "kmax_next";
    beat(2, 1, 8'h41, 1'b1, 1'b0);
    expect_frame(2, 64'd1, 64'd1, 8'h41, 1'b0, 1'b0);

    cur = "backpressure";
    @(negedge clk);
    out_ready = 1'b0;
    beat(0, 3, 8'h11, 1'b0, 1'b0);
    beat(0, 4, 8'h11, 1'b1, 1'b0);
    @(negedge clk);
    in_partial    = 99;
    in_tuser      = 8'h11;
    in_last       = 1'b0;
    in_poison     = 1'b0;
    in_valid_v[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 64'(out_valid_v[0]), 64'd1);
      chk("hold_in_ready", 64'(in_ready_v[0]), 64'd0);
      chk("hold_sum", g_sum(0), 64'd7);
      chk("hold_count", g_cnt(0), 64'd2);
      chk("hold_tuser", g_tu(0), 64'h11);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_valid", 64'(out_valid_v[0]), 64'd0);
    chk("post_in_ready", 64'(in_ready_v[0]), 64'd1);
    in_valid_v[0] = 1'b0;

    cur = "mid_reset";
    beat(0, 1, 8'h30, 1'b0, 1'b0);
    beat(0, 2, 8'h30, 1'b0, 1'b0);
    chk("frame_active", 64'(frame_active_v[0]), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("frame_active", 64'(frame_active_v[0]), 64'd0);
    chk("out_valid", 64'(out_valid_v[0]), 64'd0);
    chk("out_sum", g_sum(0), 64'd0);
    chk("out_count", g_cnt(0), 64'd0);
    chk("out_tuser", g_tu(0), 64'd0);
    chk("out_poison", 64'(out_poison_v[0]), 64'd0);
    chk("out_saturated", 64'(out_sat_v[0]), 64'd0);
    cur = "after_reset";
    beat(0, 5, 8'h31, 1'b1, 1'b0);
    expect_frame(0, 64'd5, 64'd1, 8'h31, 1'b0, 1'b0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
